life_gen_scheduler: RTL and testbench

- Sequences Game-of-Life generations over the two 1280-bit × 720-row BRAM banks (blk_ram_A / blk_ram_B) used by pixel_generator.
- Handles three phases: loading the initial grid from the AXI-Lite register file into bank A; streaming rows of the source bank into the next-state line buffer; writing result rows to the destination bank.
- Ping-pong swaps the banks at frame boundaries.
- Arbitrates each single-port bank between display row fetches (highest priority), compute fetches, init writes and result writes.

---
 rtl/life_gen_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_life_gen_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/life_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : life_gen_scheduler
// Purpose  : Sequences Game-of-Life generations over two ping-pong row banks
//            (init load, compute fetch, result write-back, frame-aligned swap).
// Revision : 1.0 - initial release
// ============================================================================
module life_gen_scheduler #(
    parameter int ROWS   = 720,
    parameter int ADDR_W = 10,
    parameter int GEN_W  = 16
) (
    input  logic              out_stream_aclk,
    input  logic              periph_reset,
    input  logic              init_start,
    input  logic              init_row_valid,
    output logic              init_row_ack,
    input  logic              pause,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_row,
    input  logic              disp_eof,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              we_a,
    output logic              we_b,
    output logic              din_sel_init,
    output logic              disp_bank,
    output logic              calc_fetch_valid,
    output logic [ADDR_W-1:0] calc_fetch_row,
    input  logic              calc_result_valid,
    input  logic [ADDR_W-1:0] calc_result_row,
    output logic [GEN_W-1:0]  gen_count,
    output logic              busy
);
    localparam int                CNT_W        = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] C_LAST_ROW   = ADDR_W'(ROWS - 1);
    localparam logic [CNT_W-1:0]  C_LAST_FETCH = CNT_W'(ROWS + 1);
    localparam logic [CNT_W-1:0]  C_ROWS       = CNT_W'(ROWS);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_INIT       = 3'd1,
        S_COMPUTE    = 3'd2,
        S_DRAIN      = 3'd3,
        S_WAIT_FRAME = 3'd4,
        S_SWAP       = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               disp_bank_q, disp_bank_d;
    logic [GEN_W-1:0]   gen_q, gen_d;
    logic [ADDR_W-1:0]  row_cnt_q, row_cnt_d;
    logic [CNT_W-1:0]   f_q, f_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
    logic               fetch_valid_q;
    logic [ADDR_W-1:0]  fetch_row_q;

    logic               w_fetch_issue;
    logic [ADDR_W-1:0]  w_fetch_row;
    logic [ADDR_W-1:0]  w_src_addr, w_dst_addr;
    logic               w_src_we, w_dst_we;
    logic               w_res_wr, w_res_done;

    // Fetch index 0 and ROWS+1 wrap to the opposite edge row for the neighbour window.
    always_comb begin
        if (f_q == '0) begin
            w_fetch_row = C_LAST_ROW;
        end else if (f_q == C_LAST_FETCH) begin
            w_fetch_row = '0;
        end else begin
            w_fetch_row = ADDR_W'(f_q - CNT_W'(1));
        end
    end

    assign w_res_wr   = calc_result_valid && (res_cnt_q != C_ROWS) &&
                        ((state_q == S_COMPUTE) || (state_q == S_DRAIN));
    assign w_res_done = ((res_cnt_q + CNT_W'(w_res_wr)) == C_ROWS);

    always_comb begin
        state_d       = state_q;
        disp_bank_d   = disp_bank_q;
        gen_d         = gen_q;
        row_cnt_d     = row_cnt_q;
        f_d           = f_q;
        res_cnt_d     = res_cnt_q + CNT_W'(w_res_wr);
        w_fetch_issue = 1'b0;
        w_src_addr    = disp_req ? disp_row : '0;
        w_src_we      = 1'b0;
        w_dst_addr    = w_res_wr ? calc_result_row : '0;
        w_dst_we      = w_res_wr;
        din_sel_init  = 1'b0;
        init_row_ack  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (init_start) begin
                    state_d     = S_INIT;
                    disp_bank_d = 1'b0;
                    row_cnt_d   = '0;
                    gen_d       = '0;
                end else if (!pause) begin
                    state_d   = S_COMPUTE;
                    f_d       = '0;
                    res_cnt_d = '0;
                end
            end
            S_INIT: begin
                if (init_row_valid && !disp_req) begin
                    w_src_addr   = row_cnt_q;
                    w_src_we     = 1'b1;
                    din_sel_init = 1'b1;
                    init_row_ack = 1'b1;
                    if (row_cnt_q == C_LAST_ROW) begin
                        state_d   = S_IDLE;
                        row_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                if (!disp_req) begin
                    w_src_addr    = w_fetch_row;
                    w_fetch_issue = 1'b1;
                    if (f_q == C_LAST_FETCH) begin
                        state_d = w_res_done ? S_WAIT_FRAME : S_DRAIN;
                    end else begin
                        f_d = f_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (w_res_done) begin
                    state_d = S_WAIT_FRAME;
                end
            end
            S_WAIT_FRAME: begin
                if (init_start) begin
                    state_d     = S_INIT;
                    disp_bank_d = 1'b0;
                    row_cnt_d   = '0;
                    gen_d       = '0;
                end else if (disp_eof && !pause) begin
                    state_d = S_SWAP;
                end
            end
            S_SWAP: begin
                state_d     = S_COMPUTE;
                disp_bank_d = ~disp_bank_q;
                gen_d       = gen_q + 1'b1;
                f_d         = '0;
                res_cnt_d   = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge out_stream_aclk) begin
        if (periph_reset) begin
            state_q       <= S_IDLE;
            disp_bank_q   <= 1'b0;
            gen_q         <= '0;
            row_cnt_q     <= '0;
            f_q           <= '0;
            res_cnt_q     <= '0;
            fetch_valid_q <= 1'b0;
            fetch_row_q   <= '0;
        end else begin
            state_q       <= state_d;
            disp_bank_q   <= disp_bank_d;
            gen_q         <= gen_d;
            row_cnt_q     <= row_cnt_d;
            f_q           <= f_d;
            res_cnt_q     <= res_cnt_d;
            fetch_valid_q <= w_fetch_issue;
            fetch_row_q   <= w_fetch_row;
        end
    end

    // The display bank is always the read source; the other bank takes results.
    assign addr_a           = disp_bank_q ? w_dst_addr : w_src_addr;
    assign we_a             = disp_bank_q ? w_dst_we   : w_src_we;
    assign addr_b           = disp_bank_q ? w_src_addr : w_dst_addr;
    assign we_b             = disp_bank_q ? w_src_we   : w_dst_we;
    assign disp_bank        = disp_bank_q;
    assign gen_count        = gen_q;
    assign calc_fetch_valid = fetch_valid_q;
    assign calc_fetch_row   = fetch_row_q;
    assign busy             = (state_q != S_IDLE) && (state_q != S_WAIT_FRAME);

endmodule
`default_nettype wire

// File: tb/tb_life_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_gen_scheduler
// Purpose  : Directed/randomized self-checking bench for life_gen_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_life_gen_scheduler;
    localparam int ROWS   = 720;
    localparam int ADDR_W = 10;
    localparam int GEN_W  = 16;

    logic              clk = 1'b0;
    logic              periph_reset, init_start, init_row_valid, init_row_ack;
    logic              pause, disp_req, disp_eof;
    logic [ADDR_W-1:0] disp_row, addr_a, addr_b, calc_fetch_row, calc_result_row;
    logic              we_a, we_b, din_sel_init, disp_bank, calc_fetch_valid;
    logic              calc_result_valid, busy;
    logic [GEN_W-1:0]  gen_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    life_gen_scheduler #(.ROWS(ROWS), .ADDR_W(ADDR_W), .GEN_W(GEN_W)) dut (
        .out_stream_aclk  (clk),
        .periph_reset     (periph_reset),
        .init_start       (init_start),
        .init_row_valid   (init_row_valid),
        .init_row_ack     (init_row_ack),
        .pause            (pause),
        .disp_req         (disp_req),
        .disp_row         (disp_row),
        .disp_eof         (disp_eof),
        .addr_a           (addr_a),
        .addr_b           (addr_b),
        .we_a             (we_a),
        .we_b             (we_b),
        .din_sel_init     (din_sel_init),
        .disp_bank        (disp_bank),
        .calc_fetch_valid (calc_fetch_valid),
        .calc_fetch_row   (calc_fetch_row),
        .calc_result_valid(calc_result_valid),
        .calc_result_row  (calc_result_row),
        .gen_count        (gen_count),
        .busy             (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fetchq[$];
        int exp_row, idx, cyc, stall, k, exp_gen;
        logic prev_iss, exp_bank;
        int prev_row;

        // Reference fetch order: wrap row, every row, wrap row.
        fetchq.push_back(ROWS - 1);
        for (int r = 0; r < ROWS; r++) fetchq.push_back(r);
        fetchq.push_back(0);
        exp_bank = 1'b0;
        exp_gen  = 0;

        periph_reset = 1'b1; init_start = 1'b0; init_row_valid = 1'b0; pause = 1'b1;
        disp_req = 1'b0; disp_row = '0; disp_eof = 1'b0;
        calc_result_valid = 1'b0; calc_result_row = '0;
        repeat (3) @(negedge clk);
        periph_reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_bank", 32'(disp_bank), 0);
        check("rst_gen", 32'(gen_count), 0);
        check("rst_we_a", 32'(we_a), 0);
        check("rst_we_b", 32'(we_b), 0);
        check("rst_ack", 32'(init_row_ack), 0);
        check("rst_fetch_valid", 32'(calc_fetch_valid), 0);
        check("rst_din_sel", 32'(din_sel_init), 0);

        // Initial grid load with display conflicts and ignored re-starts.
        @(negedge clk);
        init_start = 1'b1;
        exp_row = 0;
        cyc = 0;
        while (exp_row < ROWS && cyc < 2000) begin
            @(negedge clk);
            init_start     = ($urandom_range(0, 31) == 0);
            init_row_valid = 1'b1;
            disp_req       = (cyc == 5) || ($urandom_range(0, 15) == 0);
            disp_row       = (cyc == 5) ? ADDR_W'(300) : ADDR_W'($urandom_range(0, ROWS - 1));
            #1;
            check("init_busy", 32'(busy), 1);
            if (disp_req) begin
                check("init_stall_ack", 32'(init_row_ack), 0);
                check("init_stall_we_a", 32'(we_a), 0);
                check("init_stall_addr_a", 32'(addr_a), 32'(disp_row));
            end else begin
                check("init_ack", 32'(init_row_ack), 1);
                check("init_we_a", 32'(we_a), 1);
                check("init_din_sel", 32'(din_sel_init), 1);
                check("init_addr_a", 32'(addr_a), 32'(exp_row));
                exp_row++;
            end
            check("init_we_b", 32'(we_b), 0);
            cyc++;
        end
        check("init_rows_done", 32'(exp_row), ROWS);
        @(negedge clk);
        init_start = 1'b0; init_row_valid = 1'b0; disp_req = 1'b0;
        #1;
        check("init_idle_busy", 32'(busy), 0);
        check("init_idle_bank", 32'(disp_bank), 0);
        check("init_idle_gen", 32'(gen_count), 0);
        check("init_idle_ack", 32'(init_row_ack), 0);
        pause = 1'b0;

        // Generation 1 fetches, forced 3-cycle stall at fetch index 100.
        idx = 0; cyc = 0; stall = 0; prev_iss = 1'b0; prev_row = 0;
        while (idx < ROWS + 2 && cyc < 4000) begin
            @(negedge clk);
            if (idx == 100 && stall < 3) begin
                disp_req = 1'b1;
                stall++;
            end else begin
                disp_req = ($urandom_range(0, 7) == 0);
            end
            disp_row = ADDR_W'($urandom_range(0, ROWS - 1));
            #1;
            check("fetch_valid", 32'(calc_fetch_valid), 32'(prev_iss));
            if (prev_iss) check("fetch_row", 32'(calc_fetch_row), 32'(prev_row));
            check("fetch_addr_a", 32'(addr_a), disp_req ? 32'(disp_row) : 32'(fetchq[idx]));
            check("fetch_we_a", 32'(we_a), 0);
            check("fetch_we_b", 32'(we_b), 0);
            check("fetch_busy", 32'(busy), 1);
            prev_iss = !disp_req;
            if (!disp_req) begin
                prev_row = fetchq[idx];
                idx++;
            end
            cyc++;
        end
        check("fetch_count", 32'(idx), ROWS + 2);

        // Drain: results written into bank B with gaps and display reads on A.
        k = 0; cyc = 0;
        while (k < ROWS && cyc < 4000) begin
            @(negedge clk);
            calc_result_valid = ($urandom_range(0, 3) != 0);
            calc_result_row   = ADDR_W'(k);
            disp_req          = ($urandom_range(0, 3) == 0);
            disp_row          = ADDR_W'($urandom_range(0, ROWS - 1));
            #1;
            check("drain_fetch_valid", 32'(calc_fetch_valid), 32'(prev_iss));
            if (prev_iss) check("drain_fetch_row", 32'(calc_fetch_row), 32'(prev_row));
            prev_iss = 1'b0;
            check("drain_busy", 32'(busy), 1);
            check("res_we_b", 32'(we_b), 32'(calc_result_valid));
            check("res_we_a", 32'(we_a), 0);
            if (calc_result_valid) begin
                check("res_addr_b", 32'(addr_b), 32'(k));
                check("res_din_sel", 32'(din_sel_init), 0);
                k++;
            end
            if (disp_req) check("drain_disp_addr_a", 32'(addr_a), 32'(disp_row));
            cyc++;
        end
        check("res_count", 32'(k), ROWS);
        @(negedge clk);
        calc_result_valid = 1'b1; calc_result_row = ADDR_W'(3); disp_req = 1'b0;
        #1;
        check("wait_busy", 32'(busy), 0);
        check("wait_ignore_we_b", 32'(we_b), 0);
        check("wait_ignore_we_a", 32'(we_a), 0);

        // Swap gating: eof under pause is dropped, eof without pause swaps.
        calc_result_valid = 1'b0; pause = 1'b1; disp_eof = 1'b1;
        @(negedge clk);
        disp_eof = 1'b0;
        #1;
        check("pause_bank", 32'(disp_bank), 32'(exp_bank));
        check("pause_gen", 32'(gen_count), 32'(exp_gen));
        check("pause_busy", 32'(busy), 0);
        pause = 1'b0; disp_eof = 1'b1;
        @(negedge clk);
        disp_eof = 1'b0;
        #1;
        check("swap_busy", 32'(busy), 1);
        check("swap_bank_old", 32'(disp_bank), 32'(exp_bank));
        exp_bank = ~exp_bank;
        exp_gen  = (exp_gen + 1) % (1 << GEN_W);
        @(negedge clk);
        calc_result_valid = 1'b1; calc_result_row = ADDR_W'(5); disp_req = 1'b0;
        #1;
        check("swap_bank_new", 32'(disp_bank), 32'(exp_bank));
        check("swap_gen", 32'(gen_count), 32'(exp_gen));
        check("gen2_res_we_a", 32'(we_a), 1);
        check("gen2_res_addr_a", 32'(addr_a), 5);
        check("gen2_res_din_sel", 32'(din_sel_init), 0);
        check("gen2_fetch_addr_b", 32'(addr_b), 32'(fetchq[0]));
        check("gen2_fetch_we_b", 32'(we_b), 0);
        idx = 1;

        // Generation 2 fetch from bank B up to f=400; stray eofs are ignored.
        while (idx < 400) begin
            @(negedge clk);
            calc_result_valid = 1'b0;
            disp_eof = ($urandom_range(0, 15) == 0);
            #1;
            check("gen2_addr_b", 32'(addr_b), 32'(fetchq[idx]));
            check("gen2_we_b", 32'(we_b), 0);
            check("gen2_we_a", 32'(we_a), 0);
            idx++;
        end

        // Mid-compute reset.
        @(negedge clk);
        periph_reset = 1'b1; disp_eof = 1'b0;
        @(negedge clk);
        periph_reset = 1'b0; pause = 1'b1; calc_result_valid = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_bank", 32'(disp_bank), 0);
        check("mid_rst_gen", 32'(gen_count), 0);
        check("mid_rst_we_a", 32'(we_a), 0);
        check("mid_rst_we_b", 32'(we_b), 0);
        check("mid_rst_fetch_valid", 32'(calc_fetch_valid), 0);
        calc_result_valid = 1'b0;

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
